// File: rtl/regbank_demux_8x8_pkg.sv
// Shared definitions for the 8-register write bank: state encodings,
// bank depth and select width.
package regbank_demux_8x8_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int BANK_DEPTH = 8;
  localparam int SEL_W      = 3;

endpackage

// File: rtl/regbank_demux_8x8_decoder.sv
// 3-to-8 one-hot decoder with a load-enable gate; drives the per-register
// load strobes of the write bank.
module regbank_demux_8x8_decoder
  import regbank_demux_8x8_pkg::*;
(
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [BANK_DEPTH-1:0] onehot
);

  generate
    for (genvar gi = 0; gi < BANK_DEPTH; gi++) begin : g_dec
      assign onehot[gi] = en && (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/regbank_demux_8x8.sv
// Write side of the 8-register datapath: valid/ready byte writes into a
// one-hot addressed bank plus a sequenced 8-cycle bank-clear sweep.
module regbank_demux_8x8
  import regbank_demux_8x8_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] S,
  input  logic [WIDTH-1:0] D,
  input  logic             wr_en,
  output logic             wr_ready,
  output logic             wr_ack,
  input  logic             clr,
  output logic             clr_busy,
  output logic             clr_done,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8
);

  state_t                  state_reg;
  logic [SEL_W-1:0]        idx_reg;
  logic                    wr_ack_reg;
  logic                    clr_done_reg;
  logic [WIDTH-1:0]        bank_reg [BANK_DEPTH];

  logic                    in_clear;
  logic                    accept;
  logic                    load_en;
  logic [SEL_W-1:0]        load_sel;
  logic [WIDTH-1:0]        load_data;
  logic [BANK_DEPTH-1:0]   load_strobe;

  assign in_clear = (state_reg == ST_CLEAR);
  // A clear request in IDLE takes priority and drops a coincident write.
  assign accept    = !in_clear && wr_en && !clr;
  assign load_en   = accept || in_clear;
  assign load_sel  = in_clear ? idx_reg : S;
  assign load_data = in_clear ? RESET_VAL : D;

  regbank_demux_8x8_decoder u_decoder (
    .sel    (load_sel),
    .en     (load_en),
    .onehot (load_strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      wr_ack_reg   <= 1'b0;
      clr_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          wr_ack_reg   <= accept;
          clr_done_reg <= 1'b0;
          if (clr) begin
            state_reg <= ST_CLEAR;
            idx_reg   <= '0;
          end
        end
        ST_CLEAR: begin
          wr_ack_reg <= 1'b0;
          idx_reg    <= idx_reg + 1'b1;
          // The edge that clears the last register ends the sweep; the index wraps to 0.
          if (idx_reg == SEL_W'(BANK_DEPTH - 1)) begin
            state_reg    <= ST_IDLE;
            clr_done_reg <= 1'b1;
          end else begin
            clr_done_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          wr_ack_reg   <= 1'b0;
          clr_done_reg <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < BANK_DEPTH; gi++) begin : g_bank
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bank_reg[gi] <= RESET_VAL;
        end else if (load_strobe[gi]) begin
          bank_reg[gi] <= load_data;
        end
      end
    end
  endgenerate

  assign wr_ready = !in_clear;
  assign clr_busy = in_clear;
  assign wr_ack   = wr_ack_reg;
  assign clr_done = clr_done_reg;

  assign r1 = bank_reg[0];
  assign r2 = bank_reg[1];
  assign r3 = bank_reg[2];
  assign r4 = bank_reg[3];
  assign r5 = bank_reg[4];
  assign r6 = bank_reg[5];
  assign r7 = bank_reg[6];
  assign r8 = bank_reg[7];

endmodule

// File: tb/tb_regbank_demux_8x8.sv
// Directed bench for regbank_demux_8x8: writes, back-to-back writes, clear
// sweep ordering, write/clear priority, async reset mid-sweep, held clr.
module tb_regbank_demux_8x8;

  logic       clk;
  logic       rst;
  logic [2:0] S;
  logic [7:0] D;
  logic       wr_en;
  logic       wr_ready;
  logic       wr_ack;
  logic       clr;
  logic       clr_busy;
  logic       clr_done;
  logic [7:0] r1, r2, r3, r4, r5, r6, r7, r8;
  logic [63:0] flat;

  int n_checks;
  int n_fail;

  regbank_demux_8x8 #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .S        (S),
    .D        (D),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_ack   (wr_ack),
    .clr      (clr),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .r4       (r4),
    .r5       (r5),
    .r6       (r6),
    .r7       (r7),
    .r8       (r8)
  );

  assign flat = {r8, r7, r6, r5, r4, r3, r2, r1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] sel, input logic [7:0] data);
    S = sel; D = data; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_flat;
    logic        done_seen;
    logic        busy_exp;
    int          budget;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; S = '0; D = '0; wr_en = 1'b0; clr = 1'b0;

    // 1. Reset state and a single write
    #12;
    check("rst_bank", flat, 64'h0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_wr_ack", 64'(wr_ack), 64'd0);
    check("rst_clr_busy", 64'(clr_busy), 64'd0);
    check("rst_clr_done", 64'(clr_done), 64'd0);
    step();
    rst = 1'b0;
    write(3'd3, 8'hA5);
    check("w1_bank", flat, 64'h00000000_A5000000);
    check("w1_ack", 64'(wr_ack), 64'd1);
    step();
    check("w1_ack_drop", 64'(wr_ack), 64'd0);

    // 2. Back-to-back writes S=0..7
    for (int i = 0; i < 8; i++) begin
      S = 3'(i); D = 8'(8'h10 + i); wr_en = 1'b1;
      check($sformatf("b2b_ready_%0d", i), 64'(wr_ready), 64'd1);
      step();
      check($sformatf("b2b_ack_%0d", i), 64'(wr_ack), 64'd1);
    end
    wr_en = 1'b0;
    check("b2b_bank", flat, 64'h17161514_13121110);

    // 3. Clear sweep, one register per cycle from r1 to r8
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_flat = 64'h17161514_13121110;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("clr_busy_%0d", k), 64'(clr_busy), 64'd1);
      check($sformatf("clr_bank_%0d", k), flat, exp_flat);
      check($sformatf("clr_done_low_%0d", k), 64'(clr_done), 64'd0);
      exp_flat[k*8 +: 8] = 8'h00;
      step();
    end
    check("clr_end_busy", 64'(clr_busy), 64'd0);
    check("clr_end_done", 64'(clr_done), 64'd1);
    check("clr_end_bank", flat, 64'h0);
    check("clr_end_ready", 64'(wr_ready), 64'd1);
    step();
    check("clr_done_once", 64'(clr_done), 64'd0);

    // 4. Write coincident with clr is dropped; writes in CLEAR are ignored
    write(3'd2, 8'h77);
    check("wc_preload", flat, 64'h00000000_00770000);
    S = 3'd2; D = 8'h3C; wr_en = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    check("wc_no_ack", 64'(wr_ack), 64'd0);
    check("wc_r3_held", 64'(r3), 64'h77);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("wc_ready_%0d", k), 64'(wr_ready), 64'd0);
      check($sformatf("wc_ack_%0d", k), 64'(wr_ack), 64'd0);
      step();
    end
    wr_en = 1'b0;
    check("wc_r3_final", 64'(r3), 64'h00);
    check("wc_done", 64'(clr_done), 64'd1);
    check("wc_ack_end", 64'(wr_ack), 64'd0);
    step();

    // 5. Asynchronous reset at sweep index 4
    write(3'd4, 8'h99);
    write(3'd7, 8'h42);
    check("rm_preload", flat, 64'h42000099_00000000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #2;
    rst = 1'b1;
    #1;
    check("rm_bank_async", flat, 64'h0);
    check("rm_busy", 64'(clr_busy), 64'd0);
    check("rm_ready", 64'(wr_ready), 64'd1);
    done_seen = 1'b0;
    if (clr_done) done_seen = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (clr_done) done_seen = 1'b1;
      step();
    end
    check("rm_no_done", 64'(done_seen), 64'd0);

    // 6. clr held high for 12 cycles: sweep, done pulse, then a new sweep
    clr = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      busy_exp = (n <= 8) || (n >= 10);
      check($sformatf("hold_busy_%0d", n), 64'(clr_busy), 64'(busy_exp));
      check($sformatf("hold_done_%0d", n), 64'(clr_done), 64'(n == 9));
    end
    clr = 1'b0;
    budget = 0;
    while (!clr_done && budget < 20) begin
      step();
      budget++;
    end
    check("hold_second_done", 64'(budget), 64'd6);
    check("hold_final_busy", 64'(clr_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_demux_8x8.md
Name: regbank_demux_8x8

Overview:
- Write side of the 8-register datapath. The existing 8-to-1 byte mux selects one of eight registers for reading; this block is the matching write path.
- A 3-bit select is decoded to one-hot, and the addressed 8-bit register is loaded through a valid/ready write handshake.
- It also runs a sequenced bank-clear sweep.
- Outputs r1..r8 feed the read mux inputs i1..i8 directly.

Parameters:
- WIDTH, 8, data width of each register (the read mux fixes this at 8).
- RESET_VAL, 8'h00, value loaded by reset and by the clear sweep.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- S  input  3  write select; 0 selects r1 … 7 selects r8
- D  input  WIDTH  write data
- wr_en  input  1  write request (valid)
- wr_ready  output  1  block can accept a write this cycle
- wr_ack  output  1  one-cycle pulse, the cycle after an accepted write
- clr  input  1  request to clear the whole bank
- clr_busy  output  1  clear sweep in progress
- clr_done  output  1  one-cycle pulse after the last register is cleared
- r1..r8  output  WIDTH each  register contents, parallel to read mux

Behaviour:
- Reset (async, while rst=1):
  - r1..r8 = RESET_VAL.
  - State = IDLE, sweep index = 0.
  - wr_ready=1, wr_ack=0, clr_busy=0, clr_done=0.
- Release: first active edge after rst deasserts behaves as IDLE.
- States: IDLE and CLEAR, 1-bit state register.
- IDLE:
  - wr_ready=1.
  - Write accepted when wr_en=1 and wr_ready=1 at a rising edge: register[S] <= D on that edge.
  - Write latency: 1 edge. New value is visible on r(S+1) the cycle after the accepting edge.
  - Only the addressed register changes; the other seven hold.
  - wr_ack=1 for exactly the cycle after each accepted write.
  - Back-to-back writes every cycle are allowed, with no bubbles. wr_ack stays high continuously while writes are accepted.
- IDLE, clr=1 at an edge:
  - Go to CLEAR, sweep index = 0.
  - clr has priority over wr_en in the same cycle: that write is dropped, no register load, no wr_ack.
- CLEAR:
  - wr_ready=0, clr_busy=1.
  - Each edge: register[index] <= RESET_VAL, index += 1.
  - Index 0..7, so the sweep takes exactly 8 cycles.
  - wr_en is ignored (not queued, no wr_ack).
  - clr is ignored (no restart).
- Sweep end:
  - On the edge that clears index 7: return to IDLE, clr_done=1 for the next cycle only, clr_busy=0.
  - The 3-bit index wraps to 0 at that edge; no overflow state.
- Outputs are registered; none depend combinationally on wr_en, S or D. wr_ready and clr_busy decode from the state register only.
- rst during CLEAR: all registers go to RESET_VAL immediately, state IDLE. clr_done does not pulse.
- rst during a write cycle: rst wins, and the write is lost.
- S is sampled only on an accepting edge. The value of S at other times has no effect.

Decomposition:
- Shared include file (regbank_defs.vh) holds:
  - state encodings ST_IDLE=1'b0, ST_CLEAR=1'b1;
  - bank depth constant 8;
  - select width 3.
- Natural sub-module: decoder3to8, combinational 3-to-8 one-hot decode of S, or of the sweep index in CLEAR.
  - Output is gated by the load enable.
  - It drives the per-register load strobes, mirroring the read-side mux.

Test Plan:
1. Reset and write:
   - Stimulus: assert rst; release; write S=3, D=8'hA5, wr_en=1 for one cycle.
   - Required: r4=8'hA5 next cycle, wr_ack=1 for that cycle only; others stay 8'h00.
2. Back-to-back writes:
   - Stimulus: writes on 8 consecutive cycles, S=0..7, D=8'h10..8'h17.
   - Required: r1..r8 = 8'h10..8'h17; wr_ack high 8 consecutive cycles; wr_ready never drops.
3. Clear sweep:
   - Stimulus: with the bank loaded as in test 2, pulse clr.
   - Required:
     - clr_busy=1 for exactly 8 cycles;
     - r1 clears first, r8 last, one register per cycle;
     - clr_done pulses once;
     - all outputs 8'h00; wr_ready back to 1.
4. Write versus clear:
   - Stimulus: wr_en=1, S=2, D=8'h3C in the same cycle as clr=1; then wr_en=1 during CLEAR.
   - Required: no wr_ack; r3 ends at 8'h00; wr_ready=0 throughout CLEAR.
5. Reset mid-sweep:
   - Stimulus: assert rst asynchronously (mid-cycle) at sweep index 4.
   - Required:
     - all r = RESET_VAL immediately, without waiting for a clock edge;
     - clr_busy=0, wr_ready=1;
     - clr_done never pulses.
6. Repeated clr in CLEAR:
   - Stimulus: hold clr=1 for 12 cycles.
   - Required:
     - first sweep completes in 8 cycles and clr_done pulses;
     - a new sweep starts only on the edge after returning to IDLE, since clr is still high.
